// File: rtl/pdm_cic_array_decimator.sv
// Multichannel PDM->PCM CIC decimator: parallel per-channel integrators, one time-shared comb path.
// Word for chan 0 is valid one clk after the frame event; the output holds while !out_ready_i; a frame arriving mid-drain is dropped (overrun).
module pdm_cic_array_decimator #(
   parameter int CHANNELS = 20,
   parameter int ORDER    = 4,
   parameter int DECIM    = 16,
   parameter int OUT_W    = ORDER*$clog2(DECIM)+2,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    pdm_en_i,
   input  logic [CHANNELS-1:0]     pdm_data_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic signed [OUT_W-1:0] out_data_o,
   output logic [CH_W-1:0]         out_chan_o,
   output logic                    out_last_o,
   output logic                    overrun_o
);

   localparam int              CNT_W   = $clog2(DECIM);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECIM-1);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS-1);

   typedef enum logic {IDLE, EMIT} state_t;
   state_t state_q, state_d;

   logic [OUT_W-1:0] integ_q [CHANNELS][ORDER];
   logic [OUT_W-1:0] integ_d [CHANNELS][ORDER];
   logic [OUT_W-1:0] snap_q  [CHANNELS];
   logic [OUT_W-1:0] dly_q   [ORDER][CHANNELS];
   logic [OUT_W-1:0] stg_q   [ORDER];
   logic [OUT_W-1:0] stg_d   [ORDER];
   logic [OUT_W-1:0] data_q, data_d, acc, cx, cd;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CH_W-1:0]  chan_q, chan_d, rd_ch;
   logic             overrun_q, overrun_d;
   logic             frame_ev, accept, last_acc, load, step;

   assign frame_ev = pdm_en_i && (cnt_q == CNT_MAX);
   assign accept   = (state_q == EMIT) && out_ready_i;
   assign last_acc = accept && (chan_q == LAST_CH);
   assign load     = frame_ev && ((state_q == IDLE) || last_acc);
   assign step     = accept && !last_acc;
   assign cnt_d    = !pdm_en_i ? cnt_q : (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);

   // Integrator cascade uses each stage's freshly updated value, so no extra per-stage delay.
   always_comb begin
      acc = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         acc = pdm_data_i[c] ? OUT_W'(1) : '1;
         for (int k = 0; k < ORDER; k++) begin
            acc           = integ_q[c][k] + acc;
            integ_d[c][k] = acc;
         end
      end
   end

   // Shared comb path evaluates the word that will be presented after this edge.
   always_comb begin
      rd_ch = step ? chan_q + CH_W'(1) : '0;
      cx    = load ? integ_d[0][ORDER-1] : snap_q[rd_ch];
      cd    = '0;
      for (int k = 0; k < ORDER; k++) begin
         cd = dly_q[k][rd_ch];
         if (accept && (rd_ch == chan_q)) cd = stg_q[k];
         stg_d[k] = cx;
         cx       = cx - cd;
      end
      data_d = cx;
   end

   always_comb begin
      state_d   = state_q;
      chan_d    = chan_q;
      overrun_d = overrun_q;
      case (state_q)
         IDLE: begin
            if (frame_ev) begin
               state_d = EMIT;
               chan_d  = '0;
            end
         end
         EMIT: begin
            if (last_acc) begin
               chan_d  = '0;
               state_d = frame_ev ? EMIT : IDLE;
            end else if (accept) begin
               chan_d = chan_q + CH_W'(1);
            end
            if (frame_ev && !last_acc) overrun_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         chan_q    <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
         data_q    <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            snap_q[c] <= '0;
            for (int k = 0; k < ORDER; k++) begin
               integ_q[c][k] <= '0;
               dly_q[k][c]   <= '0;
            end
         end
         for (int k = 0; k < ORDER; k++) stg_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         chan_q    <= chan_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
         if (pdm_en_i) integ_q <= integ_d;
         if (load) begin
            for (int c = 0; c < CHANNELS; c++) snap_q[c] <= integ_d[c][ORDER-1];
         end
         if (load || step) begin
            data_q <= data_d;
            stg_q  <= stg_d;
         end
         if (accept) begin
            for (int k = 0; k < ORDER; k++) dly_q[k][chan_q] <= stg_q[k];
         end
      end
   end

   assign out_valid_o = (state_q == EMIT);
   assign out_data_o  = data_q;
   assign out_chan_o  = chan_q;
   assign out_last_o  = (state_q == EMIT) && (chan_q == LAST_CH);
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pdm_cic_array_decimator.sv
// Directed bench for pdm_cic_array_decimator at default parameters.
module tb_pdm_cic_array_decimator;

   localparam int NCH = 20;
   localparam int R   = 16;
   localparam logic signed [17:0] POS = 18'sd65536;
   localparam logic signed [17:0] NEG = -18'sd65536;
   localparam logic signed [17:0] ZER = 18'sd0;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              pdm_en = 1'b0;
   logic [NCH-1:0]    pdm_data = '0;
   logic              out_ready = 1'b1;
   logic              out_valid;
   logic signed [17:0] out_data;
   logic [4:0]        out_chan;
   logic              out_last;
   logic              overrun;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int strobes = 0;
   int mode = 0;
   logic alt = 1'b0;

   pdm_cic_array_decimator dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .pdm_en_i   (pdm_en),
      .pdm_data_i (pdm_data),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .out_chan_o (out_chan),
      .out_last_o (out_last),
      .overrun_o  (overrun)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0; pdm_en = 1'b0; pdm_data = '0; out_ready = 1'b1;
      cyc = 0; strobes = 0; alt = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one cycle of PDM stimulus (strobe every p clocks), then wait to the next sampling point.
   task automatic adv(input int p);
      pdm_en = (cyc % p == 0);
      if (pdm_en) begin
         strobes++;
         alt = ~alt;
         pdm_data = (mode == 0) ? '1 : (alt ? 20'h00080 : 20'h00000);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      tests++; if (out_data !== ZER) begin fails++; $display("FAIL reset_data got %0d exp 0", out_data); end
      tests++; if (out_chan !== 5'd0) begin fails++; $display("FAIL reset_chan got %0d exp 0", out_chan); end
      tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b exp 0", out_last); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b exp 0", overrun); end
   endtask

   task automatic test_all_ones();
      int wcnt = 0;
      int guard = 0;
      int frame;
      mode = 0; do_reset();
      while (wcnt < 7*NCH && guard < 600) begin
         if (out_valid) begin
            frame = wcnt/NCH + 1;
            tests++; if (out_chan !== 5'(wcnt % NCH)) begin fails++; $display("FAIL ones_chan got %0d exp %0d", out_chan, wcnt % NCH); end
            tests++; if (out_last !== ((wcnt % NCH) == NCH-1)) begin fails++; $display("FAIL ones_last chan %0d got %b", wcnt % NCH, out_last); end
            tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ones_overrun got %b exp 0", overrun); end
            if (frame >= 5) begin
               tests++; if (out_data !== POS) begin fails++; $display("FAIL ones_data frame %0d chan %0d got %0d exp %0d", frame, out_chan, out_data, POS); end
            end
            wcnt++;
         end
         adv(2); guard++;
      end
      tests++; if (wcnt != 7*NCH) begin fails++; $display("FAIL ones_timeout got %0d words exp %0d", wcnt, 7*NCH); end
   endtask

   task automatic test_one_channel_alt();
      int wcnt = 0;
      int guard = 0;
      int ch;
      logic signed [17:0] exp;
      mode = 1; do_reset();
      while (wcnt < 6*NCH && guard < 600) begin
         if (out_valid) begin
            ch = wcnt % NCH;
            exp = (ch == 7) ? ZER : NEG;
            tests++; if (out_chan !== 5'(ch)) begin fails++; $display("FAIL alt_chan got %0d exp %0d", out_chan, ch); end
            if (wcnt/NCH + 1 >= 5) begin
               tests++; if (out_data !== exp) begin fails++; $display("FAIL alt_data chan %0d got %0d exp %0d", ch, out_data, exp); end
            end
            wcnt++;
         end
         adv(2); guard++;
      end
      tests++; if (wcnt != 6*NCH) begin fails++; $display("FAIL alt_timeout got %0d words exp %0d", wcnt, 6*NCH); end
      mode = 0;
   endtask

   task automatic test_backpressure();
      int guard = 0;
      int exp = 0;
      bit stalled = 0;
      mode = 0; do_reset();
      while (!(out_valid && out_chan == 5'd0 && strobes/R == 6) && guard < 1000) begin adv(4); guard++; end
      tests++; if (guard >= 1000) begin fails++; $display("FAIL bp_reach got timeout exp frame 6"); end
      guard = 0;
      while (exp < NCH && guard < 300) begin
         if (out_valid && exp == 5 && !stalled) begin
            out_ready = 1'b0;
            repeat (10) begin
               adv(4);
               tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid got %b exp 1", out_valid); end
               tests++; if (out_chan !== 5'd5) begin fails++; $display("FAIL bp_hold_chan got %0d exp 5", out_chan); end
               tests++; if (out_data !== POS) begin fails++; $display("FAIL bp_hold_data got %0d exp %0d", out_data, POS); end
               tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL bp_hold_last got %b exp 0", out_last); end
            end
            out_ready = 1'b1;
            stalled = 1;
         end
         if (out_valid) begin
            tests++; if (out_chan !== 5'(exp)) begin fails++; $display("FAIL bp_chan got %0d exp %0d", out_chan, exp); end
            tests++; if (out_data !== POS) begin fails++; $display("FAIL bp_data chan %0d got %0d exp %0d", exp, out_data, POS); end
            tests++; if (out_last !== (exp == NCH-1)) begin fails++; $display("FAIL bp_last chan %0d got %b", exp, out_last); end
            exp++;
         end
         adv(4); guard++;
      end
      tests++; if (exp != NCH) begin fails++; $display("FAIL bp_timeout got %0d words exp %0d", exp, NCH); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL bp_overrun got %b exp 0", overrun); end
   endtask

   task automatic test_overrun();
      int guard = 0;
      int exp = 3;
      mode = 0; do_reset();
      while (!(out_valid && out_chan == 5'd3 && strobes/R == 5) && guard < 1000) begin adv(2); guard++; end
      tests++; if (guard >= 1000) begin fails++; $display("FAIL ovr_reach got timeout exp frame 5"); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_before got %b exp 0", overrun); end
      out_ready = 1'b0;
      repeat (40) begin
         adv(2);
         tests++; if (out_valid !== 1'b1 || out_chan !== 5'd3) begin fails++; $display("FAIL ovr_hold got v%b c%0d exp v1 c3", out_valid, out_chan); end
         tests++; if (out_data !== POS) begin fails++; $display("FAIL ovr_hold_data got %0d exp %0d", out_data, POS); end
      end
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b exp 1", overrun); end
      out_ready = 1'b1; guard = 0;
      while (exp < NCH && guard < 100) begin
         if (out_valid) begin
            tests++; if (out_chan !== 5'(exp)) begin fails++; $display("FAIL ovr_chan got %0d exp %0d", out_chan, exp); end
            tests++; if (out_data !== POS) begin fails++; $display("FAIL ovr_data chan %0d got %0d exp %0d", exp, out_data, POS); end
            exp++;
         end
         adv(2); guard++;
      end
      tests++; if (exp != NCH) begin fails++; $display("FAIL ovr_drain got %0d words exp %0d", exp, NCH); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovr_idle got %b exp 0", out_valid); end
      guard = 0;
      while (!out_valid && guard < 100) begin adv(2); guard++; end
      tests++; if (out_chan !== 5'd0 || strobes/R != 7) begin fails++; $display("FAIL ovr_next got chan %0d frame %0d exp chan 0 frame 7", out_chan, strobes/R); end
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
   endtask

   task automatic test_back_to_back();
      int guard = 0;
      bit fe;
      mode = 0; do_reset();
      while (!(out_valid && out_chan == 5'd19 && strobes/R == 6) && guard < 1000) begin adv(2); guard++; end
      tests++; if (guard >= 1000) begin fails++; $display("FAIL b2b_reach got timeout exp frame 6 chan 19"); end
      guard = 0; fe = 0;
      while (!fe && guard < 100) begin
         fe = (cyc % 2 == 0) && ((strobes + 1) % R == 0);
         out_ready = fe;
         tests++; if (out_valid !== 1'b1 || out_chan !== 5'd19) begin fails++; $display("FAIL b2b_wait got v%b c%0d exp v1 c19", out_valid, out_chan); end
         adv(2); guard++;
      end
      out_ready = 1'b1;
      tests++; if (out_valid !== 1'b1 || out_chan !== 5'd0) begin fails++; $display("FAIL b2b_restart got v%b c%0d exp v1 c0", out_valid, out_chan); end
      tests++; if (out_data !== POS) begin fails++; $display("FAIL b2b_data got %0d exp %0d", out_data, POS); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
      tests++; if (strobes/R != 7) begin fails++; $display("FAIL b2b_frame got %0d exp 7", strobes/R); end
   endtask

   task automatic test_reset_midframe();
      int guard = 0;
      mode = 0; do_reset();
      while (!(out_valid && out_chan == 5'd9) && guard < 500) begin adv(2); guard++; end
      tests++; if (guard >= 500) begin fails++; $display("FAIL rstm_reach got timeout exp chan 9"); end
      rst_n = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstm_valid got %b exp 0", out_valid); end
      tests++; if (out_data !== ZER || out_chan !== 5'd0) begin fails++; $display("FAIL rstm_data got d%0d c%0d exp 0", out_data, out_chan); end
      tests++; if (out_last !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL rstm_flags got l%b o%b exp 0", out_last, overrun); end
      @(negedge clk);
      rst_n = 1'b1; cyc = 0; strobes = 0; alt = 1'b0;
      guard = 0;
      while (strobes < R && guard < 100) begin
         adv(2); guard++;
         tests++; if (out_valid !== 1'(strobes >= R)) begin fails++; $display("FAIL rstm_wait strobe %0d got %b exp %b", strobes, out_valid, strobes >= R); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_all_ones();
      test_one_channel_alt();
      test_backpressure();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
